// File: rtl/ws2812_rx_if.sv
// ws2812_rx_if: decoded-pixel bus produced by the WS2812 receiver.
//   pixel_out      - last completed pixel word
//   pixel_valid    - one-cycle pulse when pixel_out updates
//   pixel_idx      - index of pixel_out within the current frame
//   frame_done     - one-cycle pulse on the latch gap ending a non-empty frame
//   frame_px_count - complete pixels in the frame just ended (valid with frame_done)
//   err            - one-cycle pulse on a protocol error
//   busy           - high while a frame is being received
// master: the receiver (drives everything); slave: the consumer.
interface ws2812_rx_if #(
  parameter int unsigned BITS_PER_PIXEL = 24,
  parameter int unsigned PX_COUNT_WIDTH = 6
);
  logic [BITS_PER_PIXEL-1:0] pixel_out;
  logic                      pixel_valid;
  logic [PX_COUNT_WIDTH-1:0] pixel_idx;
  logic                      frame_done;
  logic [PX_COUNT_WIDTH:0]   frame_px_count;
  logic                      err;
  logic                      busy;

  modport master (
    output pixel_out, pixel_valid, pixel_idx, frame_done, frame_px_count, err, busy
  );

  modport slave (
    input pixel_out, pixel_valid, pixel_idx, frame_done, frame_px_count, err, busy
  );
endinterface

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 single-wire receiver. Measures high-pulse widths on the
// synchronised line, reassembles MSB-first bits into pixel words, tags each
// word with its frame index and flags the low latch gap that ends a frame.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-low reset
//   din   - raw serial line, asynchronous to clk
//   bus   - ws2812_rx_if.master, decoded pixel / frame / error outputs
// Optional build macro WS2812_RX_RGB_ORDER_EN: reorder pixel_out from wire
// order GRB to RGB (requires BITS_PER_PIXEL = 24). Timing is unchanged.
// A raw din edge shows up on the outputs 3 cycles later (2 synchroniser
// flops + registered outputs).
module ws2812_rx #(
  parameter int unsigned BITS_PER_PIXEL = 24,
  parameter int unsigned PX_COUNT_WIDTH = 6,
  parameter int unsigned T_SAMPLE       = 60,
  parameter int unsigned T_MIN_HIGH     = 15,
  parameter int unsigned T_MAX_HIGH     = 150,
  parameter int unsigned RESET_CYCLES   = 5000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        din,
  ws2812_rx_if.master bus
);

  localparam int unsigned LCNT_W = $clog2(RESET_CYCLES + 1);
  localparam int unsigned HCNT_W = $clog2(T_MAX_HIGH + 2);
  localparam int unsigned BCNT_W = $clog2(BITS_PER_PIXEL + 1);
  localparam int unsigned PCNT_W = PX_COUNT_WIDTH + 1;

  localparam logic [LCNT_W-1:0] L_END      = LCNT_W'(RESET_CYCLES);
  localparam logic [HCNT_W-1:0] H_SAMPLE   = HCNT_W'(T_SAMPLE);
  localparam logic [HCNT_W-1:0] H_MIN      = HCNT_W'(T_MIN_HIGH);
  localparam logic [HCNT_W-1:0] H_MAX      = HCNT_W'(T_MAX_HIGH);
  localparam logic [BCNT_W-1:0] B_LAST     = BCNT_W'(BITS_PER_PIXEL - 1);
  localparam logic [PCNT_W-1:0] PX_FULL    = {1'b1, {PX_COUNT_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    S_SYNC,
    S_IDLE,
    S_HIGH,
    S_LOW
  } state_t;

  state_t                    r_state;
  logic                      r_meta;
  logic                      r_ds;
  logic                      r_ds_d;
  logic [LCNT_W-1:0]         r_lcnt;
  logic [HCNT_W-1:0]         r_hcnt;
  logic [BCNT_W-1:0]         r_bcnt;
  logic [PCNT_W-1:0]         r_pcnt;
  logic                      r_ovf;
  logic [BITS_PER_PIXEL-2:0] r_shift;

  logic [BITS_PER_PIXEL-1:0] r_pixel_out;
  logic                      r_pixel_valid;
  logic [PX_COUNT_WIDTH-1:0] r_pixel_idx;
  logic                      r_frame_done;
  logic [PCNT_W-1:0]         r_frame_px_count;
  logic                      r_err;
  logic                      r_busy;

  logic                      w_rise;
  logic                      w_fall;
  logic [LCNT_W-1:0]         w_lcnt_nxt;
  logic [HCNT_W-1:0]         w_hcnt_nxt;
  logic                      w_bad_width;
  logic                      w_bit;
  logic [BITS_PER_PIXEL-1:0] w_word;
  logic [BITS_PER_PIXEL-1:0] w_px;

  // Two-flop synchroniser plus one delayed copy for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta <= 1'b0;
      r_ds   <= 1'b0;
      r_ds_d <= 1'b0;
    end else begin
      r_meta <= din;
      r_ds   <= r_meta;
      r_ds_d <= r_ds;
    end
  end

  assign w_rise      = r_ds & ~r_ds_d;
  assign w_fall      = ~r_ds & r_ds_d;
  assign w_lcnt_nxt  = r_lcnt + LCNT_W'(1);
  assign w_hcnt_nxt  = r_hcnt + HCNT_W'(1);
  assign w_bad_width = (r_hcnt < H_MIN) || (r_hcnt > H_MAX);
  assign w_bit       = (r_hcnt >= H_SAMPLE);
  assign w_word      = {r_shift, w_bit};

`ifdef WS2812_RX_RGB_ORDER_EN
  // Wire order is G,R,B; present R,G,B
  assign w_px = {w_word[15:8], w_word[23:16], w_word[7:0]};
`else
  assign w_px = w_word;
`endif

  // Receiver FSM with all outputs registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= S_SYNC;
      r_lcnt           <= '0;
      r_hcnt           <= '0;
      r_bcnt           <= '0;
      r_pcnt           <= '0;
      r_ovf            <= 1'b0;
      r_shift          <= '0;
      r_pixel_out      <= '0;
      r_pixel_valid    <= 1'b0;
      r_pixel_idx      <= '0;
      r_frame_done     <= 1'b0;
      r_frame_px_count <= '0;
      r_err            <= 1'b0;
      r_busy           <= 1'b0;
    end else begin
      r_pixel_valid <= 1'b0;
      r_frame_done  <= 1'b0;
      r_err         <= 1'b0;

      case (r_state)
        // Wait for a full latch gap so reception never starts mid-frame
        S_SYNC: begin
          if (r_ds) begin
            r_lcnt <= '0;
          end else if (w_lcnt_nxt == L_END) begin
            r_lcnt  <= '0;
            r_state <= S_IDLE;
          end else begin
            r_lcnt <= w_lcnt_nxt;
          end
        end

        S_IDLE: begin
          if (w_rise) begin
            r_hcnt  <= '0;
            r_bcnt  <= '0;
            r_pcnt  <= '0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_HIGH;
          end
        end

        S_HIGH: begin
          if (w_fall) begin
            r_lcnt <= '0;
            if (w_bad_width) begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_SYNC;
            end else begin
              r_state <= S_LOW;
              // After a pixel overflow, bits are dropped until the latch gap
              if (!r_ovf) begin
                if (r_bcnt == B_LAST) begin
                  r_bcnt <= '0;
                  if (r_pcnt == PX_FULL) begin
                    r_err <= 1'b1;
                    r_ovf <= 1'b1;
                  end else begin
                    r_pixel_out   <= w_px;
                    r_pixel_valid <= 1'b1;
                    r_pixel_idx   <= r_pcnt[PX_COUNT_WIDTH-1:0];
                    r_pcnt        <= r_pcnt + PCNT_W'(1);
                  end
                end else begin
                  r_bcnt  <= r_bcnt + BCNT_W'(1);
                  r_shift <= w_word[BITS_PER_PIXEL-2:0];
                end
              end
            end
          end else begin
            // Count saturates at T_MAX_HIGH+1 because the state is left there
            r_hcnt <= w_hcnt_nxt;
            if (w_hcnt_nxt > H_MAX) begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_lcnt  <= '0;
              r_state <= S_SYNC;
            end
          end
        end

        S_LOW: begin
          if (w_rise) begin
            r_hcnt  <= HCNT_W'(1);
            r_state <= S_HIGH;
          end else if (w_lcnt_nxt == L_END) begin
            // Latch gap: close the frame, a partial word is discarded as an error
            r_lcnt           <= '0;
            r_frame_done     <= 1'b1;
            r_frame_px_count <= r_pcnt;
            r_busy           <= 1'b0;
            r_err            <= (r_bcnt != '0);
            r_state          <= S_IDLE;
          end else begin
            r_lcnt <= w_lcnt_nxt;
          end
        end

        default: r_state <= S_SYNC;
      endcase
    end
  end

  assign bus.pixel_out      = r_pixel_out;
  assign bus.pixel_valid    = r_pixel_valid;
  assign bus.pixel_idx      = r_pixel_idx;
  assign bus.frame_done     = r_frame_done;
  assign bus.frame_px_count = r_frame_px_count;
  assign bus.err            = r_err;
  assign bus.busy           = r_busy;

endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: directed bench for ws2812_rx. Drives WS2812 waveforms on din
// (T1H=80/T1L=45, T0H=40/T0L=85 cycles), records DUT events on the falling
// clock edge and checks them against hand-computed expectations.
module tb_ws2812_rx;

  localparam int unsigned BPP = 24;
  localparam int unsigned PXW = 6;

  logic clk = 1'b0;
  logic reset;
  logic din;

  ws2812_rx_if #(.BITS_PER_PIXEL(BPP), .PX_COUNT_WIDTH(PXW)) bus ();

  ws2812_rx #(
    .BITS_PER_PIXEL(BPP),
    .PX_COUNT_WIDTH(PXW),
    .T_SAMPLE(60),
    .T_MIN_HIGH(15),
    .T_MAX_HIGH(150),
    .RESET_CYCLES(5000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .din(din),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder (written only here, read by the stimulus block)
  logic [23:0] q_word[$];
  int          q_idx[$];
  int          n_err = 0;
  int          err_cyc = -1;
  int          n_fd = 0;
  int          fd_cyc = -1;
  int          fd_cnt = -1;
  logic        fd_with_err = 1'b0;
  logic        busy_prev = 1'b0;
  int          busy_rise_cyc = -1;
  int          busy_fall_cyc = -1;
  int          n_busy_fall = 0;

  always @(negedge clk) begin
    if (bus.pixel_valid) begin
      q_word.push_back(bus.pixel_out);
      q_idx.push_back(int'(bus.pixel_idx));
    end
    if (bus.err) begin
      n_err++;
      err_cyc = cyc;
    end
    if (bus.frame_done) begin
      n_fd++;
      fd_cyc = cyc;
      fd_cnt = int'(bus.frame_px_count);
      fd_with_err = bus.err;
    end
    if (!busy_prev && bus.busy) busy_rise_cyc = cyc;
    if (busy_prev && !bus.busy) begin
      busy_fall_cyc = cyc;
      n_busy_fall++;
    end
    busy_prev = bus.busy;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] exp_px(input logic [23:0] w);
`ifdef WS2812_RX_RGB_ORDER_EN
    return {w[15:8], w[23:16], w[7:0]};
`else
    return w;
`endif
  endfunction

  int last_rise = 0;
  int last_fall = 0;
  int frame_rise = -1;

  // Advance n falling edges, then step off the edge before acting
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    din = 1'b1;
    last_rise = cyc;
    if (frame_rise < 0) frame_rise = cyc;
    tick(b ? 80 : 40);
    din = 1'b0;
    last_fall = cyc;
    tick(b ? 45 : 85);
  endtask

  task automatic send_bits(input logic [23:0] w, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic low(input int n);
    din = 1'b0;
    tick(n);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, ".pixel_out"}, 32'(bus.pixel_out), 32'h0);
    chk({tag, ".pixel_valid"}, 32'(bus.pixel_valid), 32'h0);
    chk({tag, ".pixel_idx"}, 32'(bus.pixel_idx), 32'h0);
    chk({tag, ".frame_done"}, 32'(bus.frame_done), 32'h0);
    chk({tag, ".frame_px_count"}, 32'(bus.frame_px_count), 32'h0);
    chk({tag, ".err"}, 32'(bus.err), 32'h0);
    chk({tag, ".busy"}, 32'(bus.busy), 32'h0);
  endtask

  int b_pv;
  int b_err;
  int b_fd;
  int b_bf;
  int d;
  int rise_c;

  initial begin
    reset = 1'b0;
    din   = 1'b0;
    tick(3);
    chk_outputs_zero("reset");

    // Release reset; 5000 low cycles bring the receiver out of SYNC
    reset = 1'b1;
    low(5100);
    chk("sync.busy", 32'(bus.busy), 32'h0);
    chk("sync.err_count", 32'(n_err), 32'd0);

    // One pixel, then latch gap
    b_pv = q_word.size(); b_err = n_err; b_fd = n_fd;
    send_bits(24'hFF0080, 24);
    low(5100);
    chk("t1.pv_count", 32'(q_word.size() - b_pv), 32'd1);
    chk("t1.word", 32'(q_word[b_pv]), 32'(exp_px(24'hFF0080)));
    chk("t1.idx", 32'(q_idx[b_pv]), 32'd0);
    chk("t1.fd_count", 32'(n_fd - b_fd), 32'd1);
    chk("t1.fd_cycle", 32'(fd_cyc), 32'(last_fall + 5003));
    chk("t1.fd_px_count", 32'(fd_cnt), 32'd1);
    chk("t1.err_count", 32'(n_err - b_err), 32'd0);

    // Three pixels in one frame, busy spans the frame
    b_pv = q_word.size(); b_err = n_err; b_fd = n_fd; b_bf = n_busy_fall;
    frame_rise = -1;
    send_bits(24'h000001, 24);
    send_bits(24'h800000, 24);
    send_bits(24'hAAAAAA, 24);
    low(5100);
    chk("t2.pv_count", 32'(q_word.size() - b_pv), 32'd3);
    chk("t2.word0", 32'(q_word[b_pv]), 32'(exp_px(24'h000001)));
    chk("t2.word1", 32'(q_word[b_pv + 1]), 32'(exp_px(24'h800000)));
    chk("t2.word2", 32'(q_word[b_pv + 2]), 32'(exp_px(24'hAAAAAA)));
    chk("t2.idx0", 32'(q_idx[b_pv]), 32'd0);
    chk("t2.idx1", 32'(q_idx[b_pv + 1]), 32'd1);
    chk("t2.idx2", 32'(q_idx[b_pv + 2]), 32'd2);
    chk("t2.fd_px_count", 32'(fd_cnt), 32'd3);
    chk("t2.fd_cycle", 32'(fd_cyc), 32'(last_fall + 5003));
    chk("t2.busy_rise", 32'(busy_rise_cyc), 32'(frame_rise + 3));
    chk("t2.busy_fall", 32'(busy_fall_cyc), 32'(fd_cyc));
    chk("t2.busy_falls", 32'(n_busy_fall - b_bf), 32'd1);
    chk("t2.err_count", 32'(n_err - b_err), 32'd0);

    // 10-cycle glitch, then a word sent before the resync gap is ignored
    b_pv = q_word.size(); b_err = n_err; b_fd = n_fd;
    din = 1'b1;
    tick(10);
    din = 1'b0;
    last_fall = cyc;
    tick(100);
    chk("t3.err_count", 32'(n_err - b_err), 32'd1);
    chk("t3.err_cycle", 32'(err_cyc), 32'(last_fall + 3));
    chk("t3.busy", 32'(bus.busy), 32'h0);
    send_bits(24'h123456, 24);
    low(5100);
    chk("t3.pv_count", 32'(q_word.size() - b_pv), 32'd0);
    chk("t3.fd_count", 32'(n_fd - b_fd), 32'd0);
    chk("t3.err_total", 32'(n_err - b_err), 32'd1);

    // 12 bits then latch: partial word gives frame_done together with err
    b_pv = q_word.size(); b_err = n_err; b_fd = n_fd;
    send_bits(24'h000ABC, 12);
    low(5100);
    chk("t4.fd_count", 32'(n_fd - b_fd), 32'd1);
    chk("t4.err_count", 32'(n_err - b_err), 32'd1);
    chk("t4.err_with_fd", 32'(fd_with_err), 32'd1);
    chk("t4.err_cycle", 32'(err_cyc), 32'(fd_cyc));
    chk("t4.fd_px_count", 32'(fd_cnt), 32'd0);
    chk("t4.pv_count", 32'(q_word.size() - b_pv), 32'd0);

    // Line stuck high mid-frame
    b_pv = q_word.size(); b_err = n_err; b_fd = n_fd;
    send_bits(24'h000002, 2);
    din = 1'b1;
    rise_c = cyc;
    tick(200);
    chk("t5.busy", 32'(bus.busy), 32'h0);
    din = 1'b0;
    low(5100);
    d = err_cyc - rise_c;
    chk("t5.err_count", 32'(n_err - b_err), 32'd1);
    chk("t5.err_latency_ok", 32'(d >= 150 && d <= 155), 32'd1);
    chk("t5.busy_fall", 32'(busy_fall_cyc), 32'(err_cyc));
    chk("t5.fd_count", 32'(n_fd - b_fd), 32'd0);
    chk("t5.pv_count", 32'(q_word.size() - b_pv), 32'd0);

    // Colour-order word
    b_pv = q_word.size(); b_err = n_err;
    send_bits(24'h11AA55, 24);
    low(5100);
    chk("t6.pv_count", 32'(q_word.size() - b_pv), 32'd1);
    chk("t6.word", 32'(q_word[b_pv]), 32'(exp_px(24'h11AA55)));
    chk("t6.err_count", 32'(n_err - b_err), 32'd0);

    // Reset in the middle of a pixel
    send_bits(24'h000FFF, 12);
    din = 1'b1;
    tick(20);
    chk("t7.busy_before", 32'(bus.busy), 32'h1);
    reset = 1'b0;
    #1;
    chk_outputs_zero("t7.async");
    tick(2);
    din = 1'b0;
    reset = 1'b1;
    b_pv = q_word.size(); b_fd = n_fd;
    tick(2);
    send_bits(24'hFFFFFF, 24);
    chk("t7.ignored_pv", 32'(q_word.size() - b_pv), 32'd0);
    low(5100);
    chk("t7.ignored_fd", 32'(n_fd - b_fd), 32'd0);
    send_bits(24'h5A5A5A, 24);
    low(5100);
    chk("t7.pv_count", 32'(q_word.size() - b_pv), 32'd1);
    chk("t7.word", 32'(q_word[b_pv]), 32'(exp_px(24'h5A5A5A)));
    chk("t7.idx", 32'(q_idx[b_pv]), 32'd0);
    chk("t7.fd_px_count", 32'(fd_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
